// File: rtl/sram_uart_dump_pkg.sv
// rtl/sram_uart_dump_pkg.sv - shared FSM state codes and UART frame constants for the SRAM dump path
package sram_uart_dump_pkg;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_WAIT_0 = 3'd2;
   localparam logic [2:0] S_WAIT_1 = 3'd3;
   localparam logic [2:0] S_TX_HI  = 3'd4;
   localparam logic [2:0] S_TX_LO  = 3'd5;
   localparam logic [2:0] S_FINISH = 3'd6;

   // start bit + 8 data bits + stop bit
   localparam int UART_FRAME_BITS = 10;

endpackage

// File: rtl/sram_uart_dump_tx.sv
// rtl/sram_uart_dump_tx.sv - 8N1 byte serialiser; Tx_done marks the last cycle of the stop bit
module uart_tx_byte
   import sram_uart_dump_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = 434
) (
   input  logic       Clock_50,
   input  logic       Resetn,
   input  logic       Load,
   input  logic [7:0] Data,
   output logic       TX,
   output logic       Tx_done
);

   localparam int BW = $clog2(CLOCKS_PER_BIT + 1);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BIT - 1);
   localparam logic [3:0] STOP_IDX = 4'(UART_FRAME_BITS - 1);
   localparam logic [3:0] LAST_DATA_IDX = 4'(UART_FRAME_BITS - 2);

   logic          active;
   logic [BW-1:0] baud_cnt;
   logic [3:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_end;

   assign bit_end = (baud_cnt == BAUD_LAST);
   assign Tx_done = active && bit_end && (bit_idx == STOP_IDX);

   // Load wins over the running frame so a back-to-back byte starts with no idle gap
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         TX       <= 1'b1;
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else if (Load) begin
         TX       <= 1'b0;
         active   <= 1'b1;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= Data;
      end else if (active) begin
         if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == STOP_IDX) begin
               active  <= 1'b0;
               bit_idx <= '0;
            end else begin
               bit_idx <= bit_idx + 4'd1;
               if (bit_idx == LAST_DATA_IDX) begin
                  TX <= 1'b1;
               end else begin
                  TX    <= shreg[0];
                  shreg <= {1'b0, shreg[7:1]};
               end
            end
         end else begin
            baud_cnt <= baud_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/sram_uart_dump.sv
// rtl/sram_uart_dump.sv - streams an SRAM word region over UART TX, high byte first
module sram_uart_dump
   import sram_uart_dump_pkg::*;
#(
   parameter int CLOCKS_PER_BIT = 434,
   parameter int ADDR_W         = 18
) (
   input  logic              Clock_50,
   input  logic              Resetn,
   input  logic              Start,
   input  logic [ADDR_W-1:0] Base_address,
   input  logic [ADDR_W-1:0] Num_words,
   output logic [ADDR_W-1:0] SRAM_address,
   input  logic [15:0]       SRAM_read_data,
   output logic              SRAM_we_n,
   output logic              UART_TX_O,
   output logic              Busy,
   output logic              Done
);

   logic [2:0]        state;
   logic [ADDR_W-1:0] addr;
   logic [ADDR_W-1:0] remaining;
   logic [15:0]       word_buf;
   logic              load_hi;
   logic              tx_load;
   logic              tx_done;
   logic [7:0]        tx_data;

   assign SRAM_we_n = 1'b1;
   assign Busy      = (state != S_IDLE) && (state != S_FINISH);
   assign Done      = (state == S_FINISH);

   // low byte is loaded in the high byte's final stop cycle so it follows with no gap
   assign tx_load = load_hi || ((state == S_TX_HI) && tx_done);
   assign tx_data = load_hi ? word_buf[15:8] : word_buf[7:0];

   uart_tx_byte #(
      .CLOCKS_PER_BIT(CLOCKS_PER_BIT)
   ) u_tx (
      .Clock_50(Clock_50),
      .Resetn  (Resetn),
      .Load    (tx_load),
      .Data    (tx_data),
      .TX      (UART_TX_O),
      .Tx_done (tx_done)
   );

   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         state        <= S_IDLE;
         addr         <= '0;
         remaining    <= '0;
         word_buf     <= '0;
         load_hi      <= 1'b0;
         SRAM_address <= '0;
      end else begin
         load_hi <= 1'b0;
         case (state)
            S_IDLE: begin
               if (Start) begin
                  addr      <= Base_address;
                  remaining <= Num_words;
                  state     <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (remaining == '0) begin
                  state <= S_FINISH;
               end else begin
                  SRAM_address <= addr;
                  state        <= S_WAIT_0;
               end
            end
            S_WAIT_0: state <= S_WAIT_1;
            S_WAIT_1: begin
               word_buf <= SRAM_read_data;
               load_hi  <= 1'b1;
               state    <= S_TX_HI;
            end
            S_TX_HI: begin
               if (tx_done) state <= S_TX_LO;
            end
            S_TX_LO: begin
               if (tx_done) begin
                  addr      <= addr + 1'b1;
                  remaining <= remaining - 1'b1;
                  if (remaining == ADDR_W'(1)) begin
                     state <= S_FINISH;
                  end else begin
                     // next address goes out on the stop-bit edge, keeping the inter-word gap at 3 cycles
                     SRAM_address <= addr + 1'b1;
                     state        <= S_WAIT_0;
                  end
               end
            end
            S_FINISH: state <= S_IDLE;
            default:  state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_uart_dump.sv
// tb/tb_sram_uart_dump.sv - scoreboard bench: reference dump model vs decoded UART stream, addresses and Done
module tb_sram_uart_dump;

   localparam int CPB      = 4;
   localparam int AW       = 18;
   localparam int WORD_CYC = 20 * CPB + 3;

   typedef struct {
      logic [7:0] d;
      int         t;
   } frm_t;

   logic          clock_50 = 1'b0;
   logic          resetn = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] base_address = '0;
   logic [AW-1:0] num_words = '0;
   logic [AW-1:0] sram_address;
   logic [15:0]   sram_read_data = '0;
   logic          sram_we_n;
   logic          uart_tx;
   logic          busy;
   logic          done;

   logic [15:0]   mem [0:(1<<AW)-1];
   frm_t          q_frm[$];
   logic [AW-1:0] q_addr[$];
   int            q_done[$];
   int            cyc = 0;
   int            total = 0;
   int            bad = 0;
   logic          we_bad = 1'b0;
   logic [AW-1:0] last_a = '0;

   sram_uart_dump #(.CLOCKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
      .Clock_50      (clock_50),
      .Resetn        (resetn),
      .Start         (start),
      .Base_address  (base_address),
      .Num_words     (num_words),
      .SRAM_address  (sram_address),
      .SRAM_read_data(sram_read_data),
      .SRAM_we_n     (sram_we_n),
      .UART_TX_O     (uart_tx),
      .Busy          (busy),
      .Done          (done)
   );

   always #5 clock_50 = ~clock_50;
   always @(posedge clock_50) cyc <= cyc + 1;
   always @(posedge clock_50) sram_read_data <= mem[sram_address];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   task automatic push_model(input logic [AW-1:0] base, input int n, input int e);
      logic [AW-1:0] a;
      logic [15:0]   w;
      for (int i = 0; i < n; i++) begin
         a = AW'((int'(base) + i) % (1 << AW));
         w = mem[a];
         q_addr.push_back(a);
         q_frm.push_back('{w[15:8], e + 4 + i * WORD_CYC});
         q_frm.push_back('{w[7:0], e + 4 + i * WORD_CYC + 10 * CPB});
         last_a = a;
      end
      q_done.push_back((n == 0) ? e + 1 : e + 4 + n * WORD_CYC - 3);
   endtask

   task automatic issue_start(input logic [AW-1:0] base, input int n, input bit expect_it, output int e);
      @(posedge clock_50);
      #1;
      start        = 1'b1;
      base_address = base;
      num_words    = AW'(n);
      e            = cyc + 1;
      @(posedge clock_50);
      #1;
      start = 1'b0;
      if (expect_it) push_model(base, n, e);
   endtask

   task automatic wait_idle();
      int i = 0;
      while (q_done.size() != 0 && i < 2000) begin
         @(negedge clock_50);
         i++;
      end
      if (q_done.size() != 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout pending=%0d", q_done.size());
         q_done.delete();
      end
      repeat (CPB) @(negedge clock_50);
      chk("frames_left", q_frm.size(), 0);
      chk("addrs_left", q_addr.size(), 0);
      q_frm.delete();
      q_addr.delete();
   endtask

   // UART receiver: samples each bit in its middle, frame start time taken from the falling edge
   bit         rx_busy = 1'b0;
   int         rx_cnt = 0;
   int         rx_fall = 0;
   logic [9:0] rx_bits = '0;
   always @(negedge clock_50) begin
      frm_t f;
      if (sram_we_n !== 1'b1) we_bad = 1'b1;
      if (!resetn) begin
         rx_busy = 1'b0;
      end else if (!rx_busy) begin
         if (uart_tx === 1'b0) begin
            rx_busy = 1'b1;
            rx_cnt  = 0;
            rx_fall = cyc;
         end
      end else begin
         rx_cnt++;
      end
      if (rx_busy && resetn && (rx_cnt % CPB) == CPB / 2) begin
         rx_bits[rx_cnt / CPB] = uart_tx;
         if (rx_cnt / CPB == 9) begin
            rx_busy = 1'b0;
            if (q_frm.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_frame data=%0h at=%0d", rx_bits[8:1], rx_fall);
            end else begin
               f = q_frm.pop_front();
               chk("frame_data", rx_bits[8:1], f.d);
               chk("frame_time", rx_fall, f.t);
               chk("framing", {rx_bits[9], rx_bits[0]}, 2'b10);
            end
         end
      end
   end

   logic [AW-1:0] prev_a = '0;
   always @(negedge clock_50) begin
      if (!resetn) begin
         prev_a = sram_address;
      end else if (sram_address !== prev_a) begin
         prev_a = sram_address;
         if (q_addr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_addr actual=%0h", sram_address);
         end else begin
            chk("sram_addr", sram_address, q_addr.pop_front());
         end
      end
   end

   always @(negedge clock_50) begin
      if (resetn && done === 1'b1) begin
         if (q_done.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done at=%0d", cyc);
         end else begin
            chk("done_cycle", cyc, q_done.pop_front());
            chk("busy_at_done", busy, 1'b0);
         end
      end
   end

   initial begin
      int e;
      int e2;
      logic [AW-1:0] b;
      int n;
      for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);
      mem[18'h00010] = 16'hA55A;
      mem[18'h00100] = 16'h0102;
      mem[18'h00101] = 16'h0304;
      mem[18'h00102] = 16'h0506;
      mem[18'h3FFFF] = 16'hBEEF;
      mem[18'h00000] = 16'hC0DE;
      mem[18'h00020] = 16'h0735;

      repeat (3) @(posedge clock_50);
      @(negedge clock_50);
      chk("reset_tx", uart_tx, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_done", done, 1'b0);
      chk("reset_addr", sram_address, 0);
      chk("reset_we_n", sram_we_n, 1'b1);
      @(posedge clock_50);
      #1 resetn = 1'b1;

      issue_start(18'h00010, 1, 1, e);
      @(negedge clock_50);
      chk("busy_after_start", busy, 1'b1);
      wait_idle();

      issue_start(18'h00100, 3, 1, e);
      wait_idle();

      issue_start(18'h00200, 0, 1, e);
      wait_idle();

      issue_start(18'h3FFFF, 2, 1, e);
      wait_idle();

      issue_start(18'h00200, 2, 1, e);
      repeat (30) @(posedge clock_50);
      issue_start(18'h00300, 1, 0, e2);
      wait_idle();

      for (int k = 0; k < 4; k++) begin
         do b = AW'($urandom_range(0, (1 << AW) - 1)); while (b == last_a);
         n = $urandom_range(1, 3);
         issue_start(b, n, 1, e);
         wait_idle();
      end

      issue_start(18'h00020, 1, 1, e);
      while (cyc < e + 21) @(negedge clock_50);
      chk("tx_before_reset", uart_tx, 1'b0);
      resetn = 1'b0;
      #1;
      chk("tx_in_reset", uart_tx, 1'b1);
      chk("busy_in_reset", busy, 1'b0);
      q_frm.delete();
      q_addr.delete();
      q_done.delete();
      repeat (3) @(posedge clock_50);
      #1 resetn = 1'b1;

      issue_start(18'h00030, 1, 1, e);
      wait_idle();

      chk("we_n_always_high", we_bad, 1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
